// File: rtl/window_monitor_pkg.sv
// Shared types and helpers for the window monitor.
//   zone_t      : committed / raw zone encoding
//   EVT_*       : bit positions inside the packed event vector
//   zone_event  : maps a committed zone transition to its event pulse
package window_monitor_pkg;

  typedef enum logic [1:0] {
    ZONE_UNKNOWN = 2'd0,
    ZONE_BELOW   = 2'd1,
    ZONE_INSIDE  = 2'd2,
    ZONE_ABOVE   = 2'd3
  } zone_t;

  localparam int EVT_W       = 3;
  localparam int EVT_ENTER   = 0;
  localparam int EVT_EXIT_LO = 1;
  localparam int EVT_EXIT_HI = 2;

  // Only transitions touching INSIDE produce an event; BELOW<->ABOVE and
  // UNKNOWN->BELOW/ABOVE are silent.
  function automatic logic [EVT_W-1:0] zone_event(zone_t from_z, zone_t to_z);
    logic [EVT_W-1:0] e;
    e = '0;
    if (to_z == ZONE_INSIDE && from_z != ZONE_INSIDE) e[EVT_ENTER] = 1'b1;
    else if (from_z == ZONE_INSIDE && to_z == ZONE_BELOW) e[EVT_EXIT_LO] = 1'b1;
    else if (from_z == ZONE_INSIDE && to_z == ZONE_ABOVE) e[EVT_EXIT_HI] = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/window_monitor_if.sv
// Sample stream interface for the window monitor.
//   s_valid : sample valid (producer -> monitor)
//   s_ready : sample ready (monitor -> producer)
//   s_data  : N-bit unsigned sample
// Handshake: a sample transfers on a rising clk edge where s_valid and
// s_ready are both 1; s_data must be stable while s_valid is 1.
interface window_monitor_if #(parameter int N = 32);
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/window_classify.sv
// Purely combinational threshold classifier.
//   data_i : sample
//   lo_i   : lower threshold (equal counts as INSIDE)
//   hi_i   : upper threshold (equal counts as INSIDE)
//   zone_o : BELOW if data<lo, else ABOVE if data>hi, else INSIDE
module window_classify
  import window_monitor_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] data_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] hi_i,
  output zone_t        zone_o
);

  logic lt;
  logic gt;

  assign lt = data_i < lo_i;
  assign gt = data_i > hi_i;

  // lt wins over gt so a misconfigured window (lo>hi) still gives one answer.
  always_comb begin
    if (lt)      zone_o = ZONE_BELOW;
    else if (gt) zone_o = ZONE_ABOVE;
    else         zone_o = ZONE_INSIDE;
  end

endmodule

// File: rtl/window_monitor.sv
// Debounced window comparator.
//   clk, rstn         : clock, synchronous active-low reset
//   s (slave)         : sample stream, never back-pressures
//   thr_lo, thr_hi    : inclusive window thresholds
//   debounce          : extra agreeing samples required before a commit
//   zone              : committed zone (zone_t encoding)
//   evt_enter         : pulse on commit into INSIDE
//   evt_exit_lo/hi    : pulse on INSIDE->BELOW / INSIDE->ABOVE
//   cfg_err           : registered thr_lo > thr_hi
// Optional (WINDOW_MONITOR_MINMAX_EN): minmax_clr, min_val, max_val track
// the extrema of every stage-1 sample.
// Pipeline: stage 1 registers the raw zone, stage 2 debounces and commits,
// so with debounce=0 a sample accepted at t is reflected in zone at t+2.
module window_monitor
  import window_monitor_pkg::*;
#(
  parameter int N          = 32,
  parameter int DEBOUNCE_W = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  window_monitor_if.slave       s,
  input  logic [N-1:0]          thr_lo,
  input  logic [N-1:0]          thr_hi,
  input  logic [DEBOUNCE_W-1:0] debounce,
  output logic [1:0]            zone,
  output logic                  evt_enter,
  output logic                  evt_exit_lo,
  output logic                  evt_exit_hi,
  output logic                  cfg_err
`ifdef WINDOW_MONITOR_MINMAX_EN
  ,
  input  logic                  minmax_clr,
  output logic [N-1:0]          min_val,
  output logic [N-1:0]          max_val
`endif
);

  logic                  s_ready_q;
  logic                  v1_q;
  zone_t                 raw1_q;
  logic                  cfg_err_q;
  zone_t                 zone_q;
  zone_t                 cand_q, cand_d;
  logic [DEBOUNCE_W-1:0] run_q, run_d, run_inc;
  logic [EVT_W-1:0]      evt_q;
  logic                  commit;
  logic                  accept;
  zone_t                 raw_c;

  assign accept    = s.s_valid & s_ready_q;
  assign s.s_ready = s_ready_q;

  window_classify #(.N(N)) u_classify (
    .data_i (s.s_data),
    .lo_i   (thr_lo),
    .hi_i   (thr_hi),
    .zone_o (raw_c)
  );

  // The candidate is always the most recent raw zone seen by stage 2, so a
  // sample matching the committed zone breaks a run and a new run must
  // start from scratch. A config error drops the candidate back to zone.
  always_comb begin
    run_inc = (run_q == '1) ? run_q : run_q + DEBOUNCE_W'(1);
    run_d   = run_q;
    cand_d  = cand_q;
    commit  = 1'b0;
    if (cfg_err_q) begin
      run_d  = '0;
      cand_d = zone_q;
    end else if (v1_q) begin
      cand_d = raw1_q;
      if (raw1_q == zone_q) begin
        run_d = '0;
      end else begin
        run_d = (raw1_q == cand_q) ? run_inc : '0;
        if (run_d >= debounce) begin
          commit = 1'b1;
          run_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_ready_q <= 1'b0;
      v1_q      <= 1'b0;
      raw1_q    <= ZONE_UNKNOWN;
      cfg_err_q <= 1'b0;
      zone_q    <= ZONE_UNKNOWN;
      cand_q    <= ZONE_UNKNOWN;
      run_q     <= '0;
      evt_q     <= '0;
    end else begin
      s_ready_q <= 1'b1;
      v1_q      <= accept;
      raw1_q    <= raw_c;
      cfg_err_q <= thr_lo > thr_hi;
      cand_q    <= cand_d;
      run_q     <= run_d;
      evt_q     <= '0;
      if (commit) begin
        zone_q <= raw1_q;
        evt_q  <= zone_event(zone_q, raw1_q);
      end
    end
  end

  assign zone        = zone_q;
  assign evt_enter   = evt_q[EVT_ENTER];
  assign evt_exit_lo = evt_q[EVT_EXIT_LO];
  assign evt_exit_hi = evt_q[EVT_EXIT_HI];
  assign cfg_err     = cfg_err_q;

`ifdef WINDOW_MONITOR_MINMAX_EN
  logic [N-1:0] data1_q;
  logic [N-1:0] min_q;
  logic [N-1:0] max_q;

  // Extrema follow the stage-1 sample, independent of cfg_err. A clear in
  // the same cycle as a stage-1 sample seeds both extrema with it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data1_q <= '0;
      min_q   <= '1;
      max_q   <= '0;
    end else begin
      data1_q <= s.s_data;
      if (minmax_clr && v1_q) begin
        min_q <= data1_q;
        max_q <= data1_q;
      end else if (minmax_clr) begin
        min_q <= '1;
        max_q <= '0;
      end else if (v1_q) begin
        if (data1_q < min_q) min_q <= data1_q;
        if (data1_q > max_q) max_q <= data1_q;
      end
    end
  end

  assign min_val = min_q;
  assign max_val = max_q;
`endif

endmodule

// File: tb/tb_window_monitor.sv
module tb_window_monitor;

  localparam int N  = 32;
  localparam int DW = 4;

  logic          clk;
  logic          rstn;
  logic [N-1:0]  thr_lo;
  logic [N-1:0]  thr_hi;
  logic [DW-1:0] debounce;
  logic [1:0]    zone;
  logic          evt_enter;
  logic          evt_exit_lo;
  logic          evt_exit_hi;
  logic          cfg_err;
`ifdef WINDOW_MONITOR_MINMAX_EN
  logic          minmax_clr;
  logic [N-1:0]  min_val;
  logic [N-1:0]  max_val;
`endif

  window_monitor_if #(.N(N)) bus ();

  window_monitor #(.N(N), .DEBOUNCE_W(DW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s           (bus),
    .thr_lo      (thr_lo),
    .thr_hi      (thr_hi),
    .debounce    (debounce),
    .zone        (zone),
    .evt_enter   (evt_enter),
    .evt_exit_lo (evt_exit_lo),
    .evt_exit_hi (evt_exit_hi),
    .cfg_err     (cfg_err)
`ifdef WINDOW_MONITOR_MINMAX_EN
    ,
    .minmax_clr  (minmax_clr),
    .min_val     (min_val),
    .max_val     (max_val)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Zone codes: 0 unknown, 1 below, 2 inside, 3 above.
  // Debounce is modelled as a streak: number of consecutive identical raw
  // zones (differing from the committed zone); commit once streak > debounce.
  int          n_tests;
  int          n_fail;
  bit          m_ready;
  bit          m_pv;
  int          m_praw;
  logic [N-1:0] m_pdata;
  bit          m_cfg;
  int          m_zone;
  int          m_last;
  int          m_streak;
  logic [2:0]  m_evt;
  logic [N-1:0] m_min;
  logic [N-1:0] m_max;

  function automatic int classify(logic [N-1:0] d, logic [N-1:0] lo, logic [N-1:0] hi);
    if (d < lo) return 1;
    if (d > hi) return 3;
    return 2;
  endfunction

  function automatic logic [2:0] event_of(int from_z, int to_z);
    if (to_z == 2 && from_z != 2) return 3'b001;
    if (from_z == 2 && to_z == 1) return 3'b010;
    if (from_z == 2 && to_z == 3) return 3'b100;
    return 3'b000;
  endfunction

  task automatic model_edge(input bit mm_clr);
    if (!rstn) begin
      m_ready = 0; m_pv = 0; m_praw = 0; m_pdata = '0; m_cfg = 0;
      m_zone = 0; m_last = 0; m_streak = 0; m_evt = 3'b000;
      m_min = '1; m_max = '0;
      return;
    end
    m_evt = 3'b000;
    if (m_cfg) begin
      m_streak = 0;
    end else if (m_pv) begin
      if (m_praw == m_zone) m_streak = 0;
      else if (m_praw == m_last && m_streak > 0) m_streak = (m_streak < (1 << DW)) ? m_streak + 1 : m_streak;
      else m_streak = 1;
      m_last = m_praw;
      if (m_praw != m_zone && m_streak - 1 >= int'(debounce)) begin
        m_evt    = event_of(m_zone, m_praw);
        m_zone   = m_praw;
        m_streak = 0;
      end
    end
    if (mm_clr && m_pv) begin
      m_min = m_pdata; m_max = m_pdata;
    end else if (mm_clr) begin
      m_min = '1; m_max = '0;
    end else if (m_pv) begin
      if (m_pdata < m_min) m_min = m_pdata;
      if (m_pdata > m_max) m_max = m_pdata;
    end
    m_pv    = bus.s_valid && m_ready;
    m_praw  = classify(bus.s_data, thr_lo, thr_hi);
    m_pdata = bus.s_data;
    m_cfg   = thr_lo > thr_hi;
    m_ready = 1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: model the edge, then compare every output 1 time unit later.
  task automatic tick();
    bit clr_now;
`ifdef WINDOW_MONITOR_MINMAX_EN
    clr_now = minmax_clr;
`else
    clr_now = 1'b0;
`endif
    @(posedge clk);
    model_edge(clr_now);
    #1;
    chk("zone",    N'(zone), N'(m_zone));
    chk("events",  N'({evt_exit_hi, evt_exit_lo, evt_enter}), N'(m_evt));
    chk("cfg_err", N'(cfg_err), N'(m_cfg));
    chk("s_ready", N'(bus.s_ready), N'(m_ready));
`ifdef WINDOW_MONITOR_MINMAX_EN
    chk("min_val", min_val, m_min);
    chk("max_val", max_val, m_max);
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [N-1:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_tests = 0; n_fail = 0;
    rstn = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    thr_lo = 100; thr_hi = 200; debounce = 0;
`ifdef WINDOW_MONITOR_MINMAX_EN
    minmax_clr = 1'b0;
`endif
    idle(2);
    chk("reset_zone", N'(zone), 0);
    chk("reset_ready", N'(bus.s_ready), 0);
    rstn = 1'b1;
    idle(1);
    chk("ready_after_reset", N'(bus.s_ready), 1);

    // Basic enter / exit with debounce 0: visible two edges after acceptance.
    send(150);
    chk("pre_latency_zone", N'(zone), 0);
    idle(1);
    chk("enter_zone", N'(zone), 2);
    chk("enter_evt", N'(evt_enter), 1);
    send(50);
    chk("enter_evt_one_cycle", N'(evt_enter), 0);
    idle(1);
    chk("exit_lo_zone", N'(zone), 1);
    chk("exit_lo_evt", N'(evt_exit_lo), 1);
    idle(1);

    // Boundaries, BELOW->ABOVE is silent.
    send(100); send(200); send(99); send(201); idle(2);
    chk("boundary_final_zone", N'(zone), 3);

    // Debounce 2: only the third consecutive 250 commits.
    send(150); idle(2);
    debounce = 2;
    send(250); send(250); send(150); send(250); send(250);
    idle(1);
    chk("debounce_hold", N'(zone), 2);
    send(250); idle(2);
    chk("debounce_commit", N'(zone), 3);

    // Misconfigured window.
    debounce = 0;
    send(150); idle(2);
    thr_lo = 300; thr_hi = 200;
    idle(1);
    chk("cfg_err_set", N'(cfg_err), 1);
    send(500); idle(2);
    chk("cfg_err_zone_hold", N'(zone), 2);
    thr_lo = 100; thr_hi = 200;
    idle(1);
    send(500); idle(2);
    chk("cfg_restored_zone", N'(zone), 3);

    // Reset with two samples in flight.
    send(150); send(50);
    rstn = 1'b0;
    idle(1);
    chk("midreset_zone", N'(zone), 0);
    chk("midreset_ready", N'(bus.s_ready), 0);
    rstn = 1'b1;
    idle(2);

`ifdef WINDOW_MONITOR_MINMAX_EN
    send(7); send(3); send(9); idle(2);
    chk("minmax_min", min_val, 3);
    chk("minmax_max", max_val, 9);
    send(5);
    minmax_clr = 1'b1;
    idle(1);
    minmax_clr = 1'b0;
    chk("minmax_clr_min", min_val, 5);
    chk("minmax_clr_max", max_val, 5);
`endif

    // Randomized phase against the model.
    for (int i = 0; i < 600; i++) begin
      bus.s_valid = ($urandom_range(0, 9) < 7);
      bus.s_data  = $urandom_range(0, 300);
      if ($urandom_range(0, 19) == 0) debounce = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        thr_lo = $urandom_range(50, 150);
        thr_hi = $urandom_range(120, 250);
      end
      rstn = ($urandom_range(0, 99) != 0);
`ifdef WINDOW_MONITOR_MINMAX_EN
      minmax_clr = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end
    bus.s_valid = 1'b0;
    rstn = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/window_monitor.md
Name: window_monitor

Overview:
- Sequential window comparator that sits directly downstream of comp_gt/comp_lt.
- Accepts a stream of N-bit unsigned samples via valid/ready and classifies each against programmable thresholds thr_lo/thr_hi: BELOW, INSIDE or ABOVE.
- Debounces zone changes and emits one-cycle enter/exit events.
- Feeds alarm/interrupt logic.

Parameters:
N, 32, sample and threshold width (unsigned)
DEBOUNCE_W, 4, width of debounce count and internal run counter

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous active-low reset
s_valid  in  1  sample valid
s_ready  out  1  sample ready
s_data  in  N  sample value
thr_lo  in  N  lower threshold (inclusive inside)
thr_hi  in  N  upper threshold (inclusive inside)
debounce  in  DEBOUNCE_W  extra consecutive agreeing samples required before a zone commit
zone  out  2  committed zone: 0 UNKNOWN, 1 BELOW, 2 INSIDE, 3 ABOVE
evt_enter  out  1  pulse, zone committed to INSIDE
evt_exit_lo  out  1  pulse, INSIDE -> BELOW
evt_exit_hi  out  1  pulse, INSIDE -> ABOVE
cfg_err  out  1  thr_lo > thr_hi (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low.
- Reset values:
  - zone=UNKNOWN.
  - All events 0, cfg_err=0, s_ready=0.
  - Pipeline valid bits 0, run counter 0.
- s_ready is 1 from the first cycle after rstn is released. A sample is accepted when s_valid and s_ready are both 1. The block never back-pressures, so s_ready stays 1 unless in reset.
- Stage 1, cycle t+1 after acceptance at t:
  - Register the raw zone using comp_lt(s_data, thr_lo) and comp_gt(s_data, thr_hi).
  - lt gives BELOW; else gt gives ABOVE; else INSIDE.
  - s_data == thr_lo or s_data == thr_hi is INSIDE.
  - Thresholds are sampled in the same cycle as s_data.
- cfg_err is registered each cycle as thr_lo > thr_hi.
  - While the registered cfg_err is 1, stage-2 updates are suppressed, the run counter is cleared and zone holds its value.
  - Samples are still accepted and then discarded.
- Stage 2 FSM, states UNKNOWN/BELOW/INSIDE/ABOVE, advanced only on a valid stage-1 result:
  - If raw == zone: run counter cleared.
  - If raw != zone and raw == the previous candidate: increment the run counter, saturating at 2^DEBOUNCE_W-1.
  - If raw != zone and raw differs from the candidate: candidate = raw, counter = 0.
  - Commit when the counter (after this update) >= debounce. Then zone <= candidate and the counter is cleared.
  - Net effect: a commit needs debounce+1 consecutive agreeing samples.
  - debounce=0 commits on the first differing sample.
- Latency: sample accepted at t, with debounce=0 → zone and event visible at t+2.
- Events are single-cycle pulses, asserted in the same cycle zone changes:
  - evt_enter on any transition into INSIDE, including from UNKNOWN.
  - evt_exit_lo on INSIDE→BELOW.
  - evt_exit_hi on INSIDE→ABOVE.
  - BELOW↔ABOVE direct, UNKNOWN→BELOW and UNKNOWN→ABOVE raise no event.
  - At most one event per cycle.
- Gaps in s_valid do not reset debounce; only accepted samples count.
- Changing debounce mid-run takes effect on the next stage-2 update.
- rstn low mid-operation: the pipeline is flushed, in-flight samples are dropped and all outputs return to reset values the next cycle.

Optional Feature:
- Macro: WINDOW_MONITOR_MINMAX_EN.
- When defined, add outputs min_val[N-1:0] and max_val[N-1:0] plus input minmax_clr.
  - Track the extrema of all stage-1 samples, including samples taken while cfg_err=1.
  - Reset values: min=all-ones, max=0.
  - minmax_clr restores the reset values. If minmax_clr coincides with a sample, that sample becomes both min and max.
  - Comparisons use comp_lt/comp_gt.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package window_monitor_pkg holds:
  - typedef enum logic [1:0] zone_t {ZONE_UNKNOWN, ZONE_BELOW, ZONE_INSIDE, ZONE_ABOVE}.
  - Event index constants.
- Threshold classification (comp_lt + comp_gt → zone_t) is a natural sub-module, window_classify, which is purely combinational.
- Debounce and FSM stay in window_monitor.

Test Plan:
- Reset, then thr_lo=100, thr_hi=200, debounce=0, samples 150 then 50 → zone INSIDE at t+2 with evt_enter; then BELOW with evt_exit_lo, one cycle each.
- Boundaries: samples 100 and 200 → INSIDE; 99 → BELOW; 201 → ABOVE, with no event on BELOW→ABOVE.
- debounce=2, zone INSIDE, samples 250,250,150,250,250,250 → commit to ABOVE only after the 3rd consecutive 250, with a single evt_exit_hi.
- thr_lo=300, thr_hi=200 → cfg_err=1 next cycle; sample 500 leaves zone unchanged; restore thresholds → cfg_err=0 and normal classification resumes.
- Mid-run rstn=0 for 1 cycle with 2 samples in flight → zone=UNKNOWN, no events, s_ready=0 during reset, s_ready=1 the cycle after.
- With WINDOW_MONITOR_MINMAX_EN: samples 7, 3, 9 → min_val=3, max_val=9; minmax_clr together with sample 5 → min=max=5.
